// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kbd_pkg
// Brief    : Shared types, scancode constants and scancode-to-ASCII lookup
//            for the PS/2 keyboard ASCII decoder.
// Revision : 1.0 - initial release
// ============================================================================
package kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_t;

    localparam logic [7:0] c_SC_BREAK  = 8'hF0;
    localparam logic [7:0] c_SC_EXT    = 8'hE0;
    localparam logic [7:0] c_SC_LSHIFT = 8'h12;
    localparam logic [7:0] c_SC_RSHIFT = 8'h59;
    localparam logic [7:0] c_SC_CAPS   = 8'h58;

    // Returns {hit, char}; letters are folded to uppercase when upper is set.
    function automatic logic [8:0] kbd_lookup(input logic [7:0] code, input logic upper);
        logic [7:0] ch;
        logic       hit;
        ch  = 8'h00;
        hit = 1'b1;
        case (code)
            8'h45: ch = 8'h30;  8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;
            8'h26: ch = 8'h33;  8'h25: ch = 8'h34;  8'h2E: ch = 8'h35;
            8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;  8'h3E: ch = 8'h38;
            8'h46: ch = 8'h39;
            8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;
            8'h23: ch = 8'h64;  8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;
            8'h34: ch = 8'h67;  8'h33: ch = 8'h68;  8'h43: ch = 8'h69;
            8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
            8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;
            8'h4D: ch = 8'h70;  8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;
            8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;  8'h3C: ch = 8'h75;
            8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
            8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
            8'h29: ch = 8'h20;
            8'h5A: ch = 8'h0D;
            default: hit = 1'b0;
        endcase
        if (upper && (ch >= 8'h61) && (ch <= 8'h7A)) begin
            ch = ch - 8'h20;
        end
        return {hit, ch};
    endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : kbd_out_fifo
// Brief    : Power-of-two byte FIFO with occupancy count; a push on a full
//            FIFO is accepted only when a pop frees a slot in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module kbd_out_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_full
);

    localparam int c_ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_ADDR_W:0] c_FULL_CNT = (c_ADDR_W + 1)'(FIFO_DEPTH);

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic                w_pop;
    logic                w_wr;

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == c_FULL_CNT);
    assign w_pop   = i_pop && o_valid;
    assign w_wr    = i_push && (!o_full || w_pop);
    // Head is masked so the output reads 00 whenever the FIFO is empty.
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/kbd_ascii_decoder.sv
`default_nettype none
// ============================================================================
// Module   : kbd_ascii_decoder
// Brief    : PS/2 scancode set 2 to ASCII decoder with output FIFO, key
//            counter and overflow flag. Define KBD_SHIFT_CASE_EN to enable
//            shift / caps-lock uppercase letters.
// Revision : 1.0 - initial release
// ============================================================================
module kbd_ascii_decoder
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       scan_byte,
    input  logic             scan_valid,
    output logic [7:0]       ascii_data,
    output logic             ascii_valid,
    input  logic             ascii_ready,
    output logic [7:0]       last_ascii,
    output logic [CNT_W-1:0] key_count,
    output logic             caps_on,
    output logic             overflow
);

    kbd_state_t       r_state;
    logic [7:0]       r_held;
    logic [7:0]       r_last_ascii;
    logic [CNT_W-1:0] r_key_count;
    logic             r_overflow;
    logic             w_upper;
    logic             w_new_make;
    logic [8:0]       w_map;
    logic             w_push;
    logic             w_pop;
    logic             w_full;

`ifdef KBD_SHIFT_CASE_EN
    logic [1:0]       r_shift;
    logic             r_caps;
    assign w_upper = (|r_shift) ^ r_caps;
    assign caps_on = r_caps;
`else
    assign w_upper = 1'b0;
    assign caps_on = 1'b0;
`endif

    assign w_new_make = scan_valid && (r_state == ST_IDLE) && (scan_byte != c_SC_BREAK)
                        && (scan_byte != c_SC_EXT) && (scan_byte != r_held);
    assign w_map      = kbd_lookup(scan_byte, w_upper);
    assign w_push     = w_new_make && w_map[8];
    assign w_pop      = ascii_valid && ascii_ready;

    assign last_ascii = r_last_ascii;
    assign key_count  = r_key_count;
    assign overflow   = r_overflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_held       <= 8'h00;
            r_last_ascii <= 8'hFF;
            r_key_count  <= '0;
            r_overflow   <= 1'b0;
`ifdef KBD_SHIFT_CASE_EN
            r_shift      <= 2'b00;
            r_caps       <= 1'b0;
`endif
        end else begin
            if (scan_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        if (scan_byte == c_SC_BREAK) begin
                            r_state <= ST_BRK;
                        end else if (scan_byte == c_SC_EXT) begin
                            r_state <= ST_EXT;
                        end else if (scan_byte != r_held) begin
                            r_held <= scan_byte;
`ifdef KBD_SHIFT_CASE_EN
                            if (scan_byte == c_SC_LSHIFT) r_shift[0] <= 1'b1;
                            if (scan_byte == c_SC_RSHIFT) r_shift[1] <= 1'b1;
                            if (scan_byte == c_SC_CAPS)   r_caps     <= ~r_caps;
`endif
                        end
                    end
                    ST_BRK: begin
                        if (scan_byte == r_held) begin
                            r_held <= 8'h00;
                        end
`ifdef KBD_SHIFT_CASE_EN
                        if (scan_byte == c_SC_LSHIFT) r_shift[0] <= 1'b0;
                        if (scan_byte == c_SC_RSHIFT) r_shift[1] <= 1'b0;
`endif
                        r_state <= ST_IDLE;
                    end
                    ST_EXT: begin
                        r_state <= (scan_byte == c_SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
            // A dropped character still counts as a key press.
            if (w_push) begin
                r_key_count  <= r_key_count + 1'b1;
                r_last_ascii <= w_map[7:0];
                if (w_full && !w_pop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    kbd_out_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_map[7:0]),
        .i_pop   (ascii_ready),
        .o_data  (ascii_data),
        .o_valid (ascii_valid),
        .o_full  (w_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_kbd_ascii_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_kbd_ascii_decoder
// Brief    : Table-driven scoreboard bench for kbd_ascii_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kbd_ascii_decoder;

`ifdef KBD_SHIFT_CASE_EN
    localparam logic [7:0] EXP_UP   = 8'h41;
    localparam logic       EXP_CAPS = 1'b1;
`else
    localparam logic [7:0] EXP_UP   = 8'h61;
    localparam logic       EXP_CAPS = 1'b0;
`endif

    typedef struct {
        logic [7:0] code;
        logic       push;
        logic [7:0] ch;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] scan_byte;
    logic       scan_valid;
    logic [7:0] ascii_data;
    logic       ascii_valid;
    logic       ascii_ready;
    logic [7:0] last_ascii;
    logic [7:0] key_count;
    logic       caps_on;
    logic       overflow;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] sb[$];
    logic [7:0] sb_exp;
    vec_t       tbl[$];
    logic [7:0] keys  [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    logic [7:0] chars [9] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};

    kbd_ascii_decoder #(.FIFO_DEPTH(8), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_byte   (scan_byte),
        .scan_valid  (scan_valid),
        .ascii_data  (ascii_data),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .last_ascii  (last_ascii),
        .key_count   (key_count),
        .caps_on     (caps_on),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Scoreboard: each accepted handshake must match the oldest expected char.
    always @(negedge clk) begin
        if (!reset && ascii_valid && ascii_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_output: actual %02h required no entry", ascii_data);
            end else begin
                sb_exp = sb.pop_front();
                chk("fifo_data", {24'h0, ascii_data}, {24'h0, sb_exp});
            end
        end
    end

    task automatic add(input logic [7:0] code, input logic push, input logic [7:0] ch);
        vec_t v;
        v.code = code; v.push = push; v.ch = ch;
        tbl.push_back(v);
    endtask

    task automatic send(input logic [7:0] b);
        scan_byte  = b;
        scan_valid = 1'b1;
        @(posedge clk); #1;
        scan_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic press(input logic [7:0] b);
        send(b); send(8'hF0); send(b);
    endtask

    task automatic drain();
        int k = 0;
        ascii_ready = 1'b1;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk("drain_left", sb.size(), 0);
        @(posedge clk); #1;
        chk("fifo_empty", {31'h0, ascii_valid}, 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_valid",    {31'h0, ascii_valid}, 0);
        chk("rst_data",     {24'h0, ascii_data},  8'h00);
        chk("rst_last",     {24'h0, last_ascii},  8'hFF);
        chk("rst_count",    {24'h0, key_count},   0);
        chk("rst_caps",     {31'h0, caps_on},     0);
        chk("rst_overflow", {31'h0, overflow},    0);
    endtask

    initial begin
        reset = 1'b1; scan_valid = 1'b0; scan_byte = 8'h00; ascii_ready = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals();
        reset = 1'b0;
        ascii_ready = 1'b1;

        add(8'h1C,1,8'h61); add(8'hF0,0,0); add(8'h1C,0,0);
        add(8'h1C,1,8'h61); add(8'h1C,0,0); add(8'h1C,0,0); add(8'hF0,0,0); add(8'h1C,0,0);
        add(8'hE0,0,0); add(8'h75,0,0); add(8'hE0,0,0); add(8'hF0,0,0); add(8'h75,0,0);
        add(8'h16,1,8'h31); add(8'hF0,0,0); add(8'h16,0,0);
        add(8'h45,1,8'h30); add(8'hF0,0,0); add(8'h45,0,0);
        add(8'h3D,1,8'h37); add(8'hF0,0,0); add(8'h3D,0,0);
        add(8'h29,1,8'h20); add(8'hF0,0,0); add(8'h29,0,0);
        add(8'h5A,1,8'h0D); add(8'hF0,0,0); add(8'h5A,0,0);
        add(8'h1A,1,8'h7A); add(8'hF0,0,0); add(8'h1A,0,0);
        add(8'h07,0,0);     add(8'hF0,0,0); add(8'h07,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].push) sb.push_back(tbl[i].ch);
            send(tbl[i].code);
            if (i == 2) begin
                chk("first_count", {24'h0, key_count},  1);
                chk("first_last",  {24'h0, last_ascii}, 8'h61);
            end
        end
        drain();
        chk("table_count", {24'h0, key_count},  8);
        chk("table_last",  {24'h0, last_ascii}, 8'h7A);
        chk("table_ovf",   {31'h0, overflow},   0);

        // Overflow: nine keys into an eight-deep FIFO with no consumer.
        pulse_reset();
        ascii_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) sb.push_back(chars[i]);
            press(keys[i]);
            if (i == 7) chk("ovf_before", {31'h0, overflow}, 0);
        end
        chk("ovf_flag",  {31'h0, overflow},    1);
        chk("ovf_count", {24'h0, key_count},   9);
        chk("ovf_valid", {31'h0, ascii_valid}, 1);
        drain();
        chk("ovf_sticky", {31'h0, overflow}, 1);

        // Push and pop in the same cycle on a full FIFO.
        pulse_reset();
        ascii_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(chars[i]);
            press(keys[i]);
        end
        sb.push_back(chars[8]);
        scan_byte = keys[8]; scan_valid = 1'b1; ascii_ready = 1'b1;
        @(posedge clk); #1;
        scan_valid = 1'b0;
        @(posedge clk); #1;
        send(8'hF0); send(keys[8]);
        drain();
        chk("simul_ovf",   {31'h0, overflow},  0);
        chk("simul_count", {24'h0, key_count}, 9);

        // Shift and caps lock.
        pulse_reset();
        ascii_ready = 1'b1;
        send(8'h12);
        sb.push_back(EXP_UP);
        press(8'h1C);
        send(8'hF0); send(8'h12);
        press(8'h58);
        chk("caps_on", {31'h0, caps_on}, {31'h0, EXP_CAPS});
        sb.push_back(EXP_UP);
        press(8'h1C);
        send(8'h12);
        sb.push_back(8'h61);
        press(8'h1C);
        send(8'hF0); send(8'h12);
        drain();

        // Reset in the middle of an extended sequence.
        send(8'hE0);
        #2 reset = 1'b1;
        #2;
        chk_reset_vals();
        @(posedge clk); #1;
        reset = 1'b0;
        sb.push_back(8'h30);
        send(8'h45);
        drain();
        chk("post_rst_count", {24'h0, key_count},  1);
        chk("post_rst_last",  {24'h0, last_ascii}, 8'h30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
